// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one registered-read memory port
//               between an instruction-fetch port and a load/store data port.
//               Formats store lanes/byte enables and extends load data.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_size,
    input  logic          d_unsigned,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          m_en,
    output logic          m_wr_en,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic [3:0]    m_be,
    input  logic [DW-1:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t        state_q;
    logic          last_d_q;     // 1 when the data port was granted last
    logic          is_d_q;
    logic          we_q;
    logic          uns_q;
    logic [1:0]    size_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    be_q;
    logic [DW-1:0] i_rdata_q;
    logic [DW-1:0] d_rdata_q;

    logic          in_idle;
    logic          d_bad;
    logic [DW-1:0] wdata_d;
    logic [3:0]    be_d;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [DW-1:0] load_fmt;

    // Grants are only offered from IDLE and never while reset is held
    assign in_idle = rst_n && (state_q == IDLE);
    assign i_gnt   = in_idle && i_req && (!d_req || last_d_q);
    assign d_gnt   = in_idle && d_req && (!i_req || !last_d_q);

    // Illegal size or misaligned half/word data access
    assign d_bad = (d_size == 2'b11) ||
                   ((d_size == 2'b01) && d_addr[0]) ||
                   ((d_size == 2'b00) && (d_addr[1:0] != 2'b00));

    // Replicate store data across lanes and build byte enables
    always_comb begin
        wdata_d = d_wdata;
        be_d    = 4'b0000;
        case (d_size)
            2'b00: begin
                wdata_d = d_wdata;
                be_d    = 4'b1111;
            end
            2'b01: begin
                wdata_d = {2{d_wdata[15:0]}};
                be_d    = 4'b0011 << d_addr[1:0];
            end
            2'b10: begin
                wdata_d = {4{d_wdata[7:0]}};
                be_d    = 4'b0001 << d_addr[1:0];
            end
            default: begin
                wdata_d = d_wdata;
                be_d    = 4'b0000;
            end
        endcase
        if (!d_we) begin
            be_d = 4'b0000;
        end
    end

    // Select the addressed lane of the read word and extend it
    always_comb begin
        case (addr_q[1:0])
            2'd1:    byte_sel = m_rdata[15:8];
            2'd2:    byte_sel = m_rdata[23:16];
            2'd3:    byte_sel = m_rdata[31:24];
            default: byte_sel = m_rdata[7:0];
        endcase
        half_sel = addr_q[1] ? m_rdata[31:16] : m_rdata[15:0];
        case (size_q)
            2'b01:   load_fmt = {{16{!uns_q && half_sel[15]}}, half_sel};
            2'b10:   load_fmt = {{24{!uns_q && byte_sel[7]}}, byte_sel};
            default: load_fmt = m_rdata;
        endcase
    end

    // Memory-side outputs are only live while issuing
    assign m_en    = (state_q == ISSUE);
    assign m_wr_en = (state_q == ISSUE) && is_d_q && we_q;
    assign m_be    = (state_q == ISSUE) ? be_q : 4'b0000;
    assign m_addr  = {addr_q[AW-1:2], 2'b00};
    assign m_wdata = wdata_q;

    // Response side: pass read data through in RESP, hold it otherwise
    assign i_rvalid = (state_q == RESP) && !is_d_q;
    assign d_rvalid = (state_q == RESP) && is_d_q;
    assign i_rdata  = i_rvalid ? m_rdata  : i_rdata_q;
    assign d_rdata  = d_rvalid ? load_fmt : d_rdata_q;
    assign d_err    = (state_q == ERR);

    // Arbitration FSM, command capture and read-data hold registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b1;
            is_d_q    <= 1'b0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= 4'b0000;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_gnt) begin
                        last_d_q <= 1'b0;
                        is_d_q   <= 1'b0;
                        we_q     <= 1'b0;
                        addr_q   <= i_addr;
                        be_q     <= 4'b0000;
                        state_q  <= ISSUE;
                    end else if (d_gnt) begin
                        last_d_q <= 1'b1;
                        is_d_q   <= 1'b1;
                        we_q     <= d_we;
                        uns_q    <= d_unsigned;
                        size_q   <= d_size;
                        addr_q   <= d_addr;
                        wdata_q  <= wdata_d;
                        be_q     <= be_d;
                        state_q  <= d_bad ? ERR : ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= (is_d_q && we_q) ? IDLE : RESP;
                end
                RESP: begin
                    i_rdata_q <= i_rdata;
                    d_rdata_q <= d_rdata;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter with directed cases
//               and randomized transactions against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        m_en;
    logic        m_wr_en;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_rdata;

    int vectors    = 0;
    int miscompares = 0;
    bit last_d     = 1'b1;   // model: data port granted last

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_en(m_en), .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_be(m_be), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run one transaction whose grant cycle is now; optional fixed read word
    task automatic run_granted(input bit side_d, input bit fix_mrd, input logic [31:0] mrd_in);
        logic [31:0] a;
        logic        we;
        logic        uns;
        int          sz;
        int          lo;
        bit          err;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] mrd;
        logic [31:0] v;
        logic [31:0] exp_rd;
        vectors++;
        if (i_gnt !== !side_d || d_gnt !== side_d) begin
            miscompares++;
            $display("FAIL grant: got i=%b d=%b expected i=%b d=%b", i_gnt, d_gnt, !side_d, side_d);
        end
        last_d = side_d;
        a   = side_d ? d_addr : i_addr;
        we  = side_d ? d_we : 1'b0;
        uns = d_unsigned;
        sz  = side_d ? int'(d_size) : 0;
        lo  = int'(a % 4);
        err = side_d && ((sz == 3) || (sz == 1 && (lo % 2) != 0) || (sz == 0 && lo != 0));
        be  = 4'd0;
        wd  = 32'd0;
        if (we) begin
            if (sz == 0) begin be = 4'd15; wd = d_wdata; end
            else if (sz == 1) begin be = 4'(3 * (2 ** lo)); wd = (d_wdata & 32'hFFFF) * 32'h00010001; end
            else begin be = 4'(2 ** lo); wd = (d_wdata & 32'hFF) * 32'h01010101; end
        end
        @(posedge clk); #1;
        if (side_d) begin
            d_req = 1'b0; d_we = 1'($urandom); d_size = 2'($urandom);
            d_unsigned = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
        end else begin
            i_req = 1'b0; i_addr = $urandom;
        end
        if (err) begin
            vectors++;
            if (d_err !== 1'b1 || m_en !== 1'b0 || i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
                miscompares++;
                $display("FAIL err_cycle: got err=%b m_en=%b gnt=%b%b expected err=1 m_en=0 gnt=00", d_err, m_en, i_gnt, d_gnt);
            end
            @(posedge clk); #1;
            vectors++;
            if (d_err !== 1'b0 || d_rvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL err_end: got err=%b rvalid=%b expected 0 0", d_err, d_rvalid);
            end
        end else begin
            vectors++;
            if (m_en !== 1'b1 || m_wr_en !== we || m_addr !== (a & 32'hFFFF_FFFC) ||
                m_be !== be || d_err !== 1'b0 || i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
                miscompares++;
                $display("FAIL issue: got en=%b we=%b addr=%h be=%b err=%b expected en=1 we=%b addr=%h be=%b err=0",
                         m_en, m_wr_en, m_addr, m_be, d_err, we, a & 32'hFFFF_FFFC, be);
            end
            if (we) begin
                vectors++;
                if (m_wdata !== wd) begin
                    miscompares++;
                    $display("FAIL store_wdata: got %h expected %h", m_wdata, wd);
                end
                @(posedge clk); #1;
                vectors++;
                if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0 || m_en !== 1'b0) begin
                    miscompares++;
                    $display("FAIL store_end: got rvalid=%b%b m_en=%b expected 00 0", i_rvalid, d_rvalid, m_en);
                end
            end else begin
                @(posedge clk); #1;
                mrd = fix_mrd ? mrd_in : $urandom;
                m_rdata = mrd;
                if (sz == 0) begin
                    exp_rd = mrd;
                end else if (sz == 1) begin
                    v = (mrd >> (16 * (lo / 2))) & 32'hFFFF;
                    exp_rd = uns ? v : (v ^ 32'h8000) - 32'h8000;
                end else begin
                    v = (mrd >> (8 * lo)) & 32'hFF;
                    exp_rd = uns ? v : (v ^ 32'h80) - 32'h80;
                end
                #1;
                vectors++;
                if (side_d && (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== exp_rd || m_en !== 1'b0)) begin
                    miscompares++;
                    $display("FAIL d_resp: got rvalid=%b rdata=%h m_en=%b expected rvalid=1 rdata=%h m_en=0", d_rvalid, d_rdata, m_en, exp_rd);
                end
                if (!side_d && (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== exp_rd || m_en !== 1'b0)) begin
                    miscompares++;
                    $display("FAIL i_resp: got rvalid=%b rdata=%h m_en=%b expected rvalid=1 rdata=%h m_en=0", i_rvalid, i_rdata, m_en, exp_rd);
                end
                @(posedge clk); #1;
                m_rdata = $urandom;
                #1;
                vectors++;
                if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || (side_d ? d_rdata : i_rdata) !== exp_rd) begin
                    miscompares++;
                    $display("FAIL rdata_hold: got rvalid=%b%b rdata=%h expected 00 %h", i_rvalid, d_rvalid, side_d ? d_rdata : i_rdata, exp_rd);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, d_err, m_en, m_wr_en} !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0000000", {i_gnt, d_gnt, i_rvalid, d_rvalid, d_err, m_en, m_wr_en});
        end
        vectors++;
        if (i_rdata !== 32'd0 || d_rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h %h expected 0 0", i_rdata, d_rdata);
        end
        vectors++;
        if (m_addr !== 32'd0 || m_wdata !== 32'd0 || m_be !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_mem: got addr=%h wdata=%h be=%b expected 0", m_addr, m_wdata, m_be);
        end
        i_req = 1'b0; d_req = 1'b0;
        last_d = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h104;
        #1;
        run_granted(1'b0, 1'b1, 32'hDEADBEEF);
    endtask

    task automatic test_byte_store();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_unsigned = 1'b0;
        d_addr = 32'h203; d_wdata = 32'h0000_00A5;
        #1;
        run_granted(1'b1, 1'b0, 32'd0);
    endtask

    task automatic test_half_load();
        for (int u = 0; u < 2; u++) begin
            @(negedge clk);
            d_req = 1'b1; d_we = 1'b0; d_size = 2'b01; d_unsigned = 1'(u);
            d_addr = 32'h12; d_wdata = 32'd0;
            #1;
            run_granted(1'b1, 1'b1, 32'h8001_7FFF);
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_unsigned = 1'b0; d_addr = 32'h6;
        #1;
        run_granted(1'b1, 1'b0, 32'd0);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b11; d_addr = 32'h8;
        #1;
        run_granted(1'b1, 1'b0, 32'd0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h40;
        #1;
        vectors++;
        if (d_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_grant: got %b expected 1", d_gnt);
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        vectors++;
        if (m_en !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_issue: got m_en=%b expected 1", m_en);
        end
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            vectors++;
            if ({d_rvalid, i_rvalid, d_err, m_en, m_wr_en, m_be} !== 9'd0 || d_rdata !== 32'd0) begin
                miscompares++;
                $display("FAIL rmid_abandon: got ctl=%b rdata=%h expected 0", {d_rvalid, i_rvalid, d_err, m_en, m_wr_en, m_be}, d_rdata);
            end
        end
        last_d = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_unsigned = 1'b0; d_addr = 32'h41;
        #1;
        run_granted(1'b1, 1'b0, 32'd0);
    endtask

    task automatic test_back_to_back();
        int  next_t;
        bit  exp_i;
        rst_n = 1'b0;
        i_req = 1'b1; i_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 32'h400; d_wdata = 32'h1234_5678;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_t = 0;
        exp_i  = 1'b1;
        for (int t = 0; t < 16; t++) begin
            #1;
            vectors++;
            if (i_gnt !== (t == next_t && exp_i) || d_gnt !== (t == next_t && !exp_i)) begin
                miscompares++;
                $display("FAIL alternate t=%0d: got i=%b d=%b expected i=%b d=%b",
                         t, i_gnt, d_gnt, (t == next_t && exp_i), (t == next_t && !exp_i));
            end
            if (t == next_t) begin
                next_t = next_t + (exp_i ? 3 : 2);
                exp_i  = !exp_i;
            end
            @(negedge clk);
        end
        i_req = 1'b0; d_req = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        last_d = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int  pat;
        bit  first_d;
        for (int n = 0; n < 40; n++) begin
            pat = $urandom_range(0, 2);
            @(negedge clk);
            if (pat != 1) begin
                i_req = 1'b1; i_addr = $urandom;
            end
            if (pat != 0) begin
                d_req = 1'b1; d_we = 1'($urandom); d_size = 2'($urandom);
                d_unsigned = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
            end
            #1;
            if (pat == 2) begin
                first_d = !last_d;
                run_granted(first_d, 1'b0, 32'd0);
                run_granted(!first_d, 1'b0, 32'd0);
            end else begin
                run_granted(pat == 1, 1'b0, 32'd0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_unsigned = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0; m_rdata = 32'd0;
        test_reset();
        test_fetch();
        test_byte_store();
        test_half_load();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits; only 32 is supported.
REQ-003 Port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 Port rst_n  input  1  synchronous, active-low reset.
REQ-005 Port i_req  input  1  instruction-fetch request, held until granted.
REQ-006 Port i_addr  input  AW  fetch byte address; bits [1:0] are ignored.
REQ-007 Port i_gnt  output  1  fetch request accepted this cycle.
REQ-008 Port i_rvalid  output  1  i_rdata is valid this cycle.
REQ-009 Port i_rdata  output  DW  fetched word.
REQ-010 Port d_req  input  1  data request, held until granted.
REQ-011 Port d_we  input  1  1 = store, 0 = load.
REQ-012 Port d_size  input  2  access size: 00 word, 01 half, 10 byte, 11 illegal.
REQ-013 Port d_unsigned  input  1  load extension: 1 = zero-extend, 0 = sign-extend.
REQ-014 Port d_addr  input  AW  data byte address.
REQ-015 Port d_wdata  input  DW  store data, right-justified.
REQ-016 Port d_gnt  output  1  data request accepted this cycle.
REQ-017 Port d_rvalid  output  1  d_rdata is valid this cycle.
REQ-018 Port d_rdata  output  DW  formatted load data.
REQ-019 Port d_err  output  1  one-cycle pulse flagging a misaligned or illegal access.
REQ-020 Port m_en  output  1  memory enable.
REQ-021 Port m_wr_en  output  1  memory write qualifier.
REQ-022 Port m_addr  output  AW  memory address.
REQ-023 Port m_wdata  output  DW  lane-aligned write data.
REQ-024 Port m_be  output  4  byte-lane write enables; bit n enables lane n (bits 8n+7:8n).
REQ-025 Port m_rdata  input  DW  memory read data, registered, valid the cycle after m_en.

Function
REQ-026 The FSM SHALL have states IDLE, ISSUE, RESP and ERR.
REQ-027 In IDLE with any request pending, the block SHALL assert exactly one of i_gnt/d_gnt combinationally, register the command and leave IDLE on the next edge.
REQ-028 Arbitration SHALL be round-robin on a 1-bit last-grant pointer; a lone requester always wins; when both request, the side not granted last wins.
REQ-029 A granted load or fetch SHALL follow IDLE -> ISSUE -> RESP -> IDLE, with rvalid high in RESP (grant cycle G, rvalid in G+2).
REQ-030 A granted store SHALL follow IDLE -> ISSUE -> IDLE and produce no rvalid.
REQ-031 In ISSUE, m_en SHALL be 1 and m_addr SHALL be {addr[AW-1:2],2'b00}.
REQ-032 In every state other than ISSUE, m_en, m_wr_en and m_be SHALL be 0.
REQ-033 In ISSUE, m_wr_en SHALL equal d_we for data commands and 0 for fetches.
REQ-034 m_be SHALL be 4'b0000 for loads and fetches; for stores it SHALL be 1111 (word), 0011<<a (half) or 0001<<a (byte), where a = addr[1:0].
REQ-035 m_wdata SHALL be the word as-is for word stores, {2{d_wdata[15:0]}} for half stores and {4{d_wdata[7:0]}} for byte stores.
REQ-036 For loads, d_rdata SHALL be the lane selected by the captured addr[1:0] (byte: 8*a; half: 16*a[1]), zero- or sign-extended per the captured d_unsigned; word loads SHALL pass m_rdata unchanged.
REQ-037 i_rdata SHALL equal m_rdata in RESP.
REQ-038 rdata outputs SHALL hold their last value outside RESP.
REQ-039 A data command with d_size=11, half with addr[0]=1, or word with addr[1:0]!=0 SHALL still be granted, SHALL skip memory and SHALL go IDLE -> ERR -> IDLE with d_err=1 only in ERR.
REQ-040 An erroneous data command SHALL update the round-robin pointer.
REQ-041 Grants SHALL be asserted only in IDLE; requests arriving in other states SHALL wait.
REQ-042 Command inputs SHALL be sampled only in the grant cycle.

Reset
REQ-043 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE, the pointer SHALL be set to "data granted last", and every output SHALL be 0.
REQ-044 Reset asserted in ISSUE or RESP SHALL abandon the transaction with no rvalid or err pulse.

Verification
REQ-045 Fetch i_addr=0x104 with m_rdata=0xDEADBEEF -> i_gnt at G, m_en=1, m_addr=0x104, m_be=0000 at G+1, i_rvalid=1 with i_rdata=0xDEADBEEF at G+2.
REQ-046 Byte store d_addr=0x203, d_wdata=0x000000A5 -> m_be=1000, m_wdata=0xA5A5A5A5, m_wr_en=1 at G+1, no d_rvalid.
REQ-047 Signed half load d_addr=0x12, m_rdata=0x8001_7FFF -> d_rdata=0xFFFF8001; the same load with d_unsigned=1 -> 0x00008001.
REQ-048 i_req and d_req both held high from reset -> grants alternate I, D, I, D, one every 3 cycles (stores every 2).
REQ-049 Word load d_addr=0x6 -> d_gnt, m_en never 1, d_err=1 at G+1; then IDLE.
REQ-050 rst_n=0 during ISSUE of a load -> no d_rvalid, all outputs 0, next request granted normally.
